// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared constants and helpers for input_cond
package input_cond_pkg;

  localparam int TICKS_PER_MS_27M = 27000;

  // Timeout-select values driven onto to_limit_ms by the software-facing glue.
  localparam int TO_OFF = 0;
  localparam int TO_3S  = 3000;
  localparam int TO_10S = 10000;
  localparam int TO_30S = 30000;

  // Bits needed for a counter running 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_cond_debounce_ch.sv
// rtl/input_cond_debounce_ch.sv - one channel: synchroniser, debounce counter, edge pulses
module debounce_ch
  import input_cond_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter logic IDLE_LEVEL   = 1'b1,
  parameter int   DEBOUNCE_CYC = 540000
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  generate
    if (DEBOUNCE_CYC == 0) begin : g_bypass
      always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
          clean <= IDLE_LEVEL;
          rise  <= 1'b0;
          fall  <= 1'b0;
        end else begin
          clean <= synced;
          rise  <= synced & ~clean;
          fall  <= ~synced & clean;
        end
      end
    end else begin : g_filt
      localparam int DW = cnt_w(DEBOUNCE_CYC);
      localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYC - 1);
      logic [DW-1:0] dcnt;

      // The input must disagree with clean for DEBOUNCE_CYC consecutive cycles.
      always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
          dcnt  <= '0;
          clean <= IDLE_LEVEL;
          rise  <= 1'b0;
          fall  <= 1'b0;
        end else begin
          rise <= 1'b0;
          fall <= 1'b0;
          if (synced == clean) begin
            dcnt <= '0;
          end else if (dcnt == DLAST) begin
            dcnt  <= '0;
            clean <= synced;
            rise  <= synced;
            fall  <= ~synced;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/input_cond.sv
// rtl/input_cond.sv - input conditioning: per-channel debounce, ms prescaler, activity timeout
// Optional long-press detection is built when INPUT_COND_LONG_PRESS_EN is defined.
module input_cond
  import input_cond_pkg::*;
#(
  parameter int   NUM_CH       = 2,
  parameter int   SYNC_STAGES  = 2,
  parameter logic IDLE_LEVEL   = 1'b1,
  parameter int   TICKS_PER_MS = TICKS_PER_MS_27M,
  parameter int   DEBOUNCE_MS  = 20,
  parameter int   TO_W         = 15
`ifdef INPUT_COND_LONG_PRESS_EN
  , parameter int LONG_PRESS_MS = 1000
`endif
) (
  input  logic              clk27,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic              ext_event,
  input  logic [TO_W-1:0]   to_limit_ms,
  output logic [NUM_CH-1:0] clean,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              ms_tick,
  output logic              timeout
`ifdef INPUT_COND_LONG_PRESS_EN
  , output logic [NUM_CH-1:0] long_press
`endif
);

  localparam int DEBOUNCE_CYC = DEBOUNCE_MS * TICKS_PER_MS;
  localparam int PW = cnt_w(TICKS_PER_MS);
  localparam logic [PW-1:0]   PLAST  = PW'(TICKS_PER_MS - 1);
  localparam logic [TO_W-1:0] TO_MAX = '1;

  logic [PW-1:0]   pcnt;
  logic [TO_W-1:0] to_ms;
  logic            ext_event_prev;
  logic            lp_act;
  logic            activity;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .IDLE_LEVEL  (IDLE_LEVEL),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_ch (
      .clk27  (clk27),
      .reset_n(reset_n),
      .raw    (raw_in[i]),
      .clean  (clean[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign ms_tick  = (pcnt == PLAST);
  assign activity = (|rise) | (|fall) | (ext_event != ext_event_prev) | lp_act;

  // Activity restarts the ms phase as well as the counter, so every timeout is a whole number of ms.
  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      pcnt           <= '0;
      to_ms          <= '0;
      timeout        <= 1'b0;
      ext_event_prev <= 1'b0;
    end else begin
      ext_event_prev <= ext_event;
      timeout <= !activity && (to_limit_ms != '0) && (to_ms >= to_limit_ms);
      if (activity) begin
        pcnt  <= '0;
        to_ms <= '0;
      end else if (ms_tick) begin
        pcnt <= '0;
        if (to_ms != TO_MAX) to_ms <= to_ms + 1'b1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

`ifdef INPUT_COND_LONG_PRESS_EN
  localparam int LW = cnt_w(LONG_PRESS_MS + 1);
  localparam logic [LW-1:0] LFIRE = LW'(LONG_PRESS_MS - 1);
  localparam logic [LW-1:0] LHOLD = LW'(LONG_PRESS_MS);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lp
    logic [LW-1:0] lcnt;

    // Fires on the tick that brings lcnt to LONG_PRESS_MS; lcnt then parks there until release.
    assign long_press[i] = (clean[i] != IDLE_LEVEL) && ms_tick && (lcnt == LFIRE);

    always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n)                        lcnt <= '0;
      else if (clean[i] == IDLE_LEVEL)     lcnt <= '0;
      else if (ms_tick && lcnt != LHOLD)   lcnt <= lcnt + 1'b1;
    end
  end

  assign lp_act = |long_press;
`else
  assign lp_act = 1'b0;
`endif

endmodule

// File: doc/input_cond.md
Name: input_cond

Overview:
- Parametrised successor to the ad-hoc button and IR synchronizers and the LCD-backlight timeout counters in the top level.
- Synchronises NUM_CH asynchronous control inputs and debounces each one. Produces edge pulses from the debounced levels.
- Keeps an activity timer with a programmable millisecond limit that drives the backlight-timeout flag.
- Sits in the clk27 domain between the board pins and the sys PIO / LCD backlight logic.

Parameters:
- NUM_CH, 2: number of input channels.
- SYNC_STAGES, 2: synchronizer depth. Minimum 2.
- IDLE_LEVEL, 1'b1: level of each channel after reset (inactive state; buttons are active-low).
- TICKS_PER_MS, 27000: clk27 cycles per millisecond tick.
- DEBOUNCE_MS, 20: debounce time in ms. 0 bypasses debouncing.
- TO_W, 15: width of the activity millisecond counter.

Ports:
- clk27  in  1  system clock.
- reset_n  in  1  async active-low reset.
- raw_in  in  NUM_CH  asynchronous inputs.
- ext_event  in  1  toggle-type activity event; any change counts as activity.
- to_limit_ms  in  TO_W  timeout limit in ms. 0 disables the timeout.
- clean  out  NUM_CH  debounced levels.
- rise  out  NUM_CH  1-cycle pulse on a 0->1 change of clean.
- fall  out  NUM_CH  1-cycle pulse on a 1->0 change of clean.
- ms_tick  out  1  1-cycle pulse once per ms.
- timeout  out  1  activity timeout reached.
- long_press  out  NUM_CH  present only with the optional feature.

Behaviour:
- Reset (async, reset_n=0):
  - All sync flops and clean = {NUM_CH{IDLE_LEVEL}}.
  - rise, fall, ms_tick, timeout, long_press = 0.
  - All counters = 0. ext_event_prev = 0.
- Synchroniser: synced[i] = raw_in[i] delayed by SYNC_STAGES flops.
- Debounce, per channel, with DEBOUNCE_CYC = DEBOUNCE_MS*TICKS_PER_MS:
  - Cycle counter dcnt.
  - If synced == clean: dcnt <= 0.
  - Otherwise dcnt increments. When dcnt == DEBOUNCE_CYC-1, clean <= synced, dcnt <= 0, and rise/fall pulse in the same cycle clean changes.
  - A glitch shorter than DEBOUNCE_CYC cycles produces no change.
  - DEBOUNCE_MS=0: clean <= synced every cycle.
  - Total latency from a raw edge to clean is SYNC_STAGES + DEBOUNCE_CYC cycles.
- Prescaler:
  - pcnt counts 0..TICKS_PER_MS-1 and wraps.
  - ms_tick=1 in the cycle pcnt == TICKS_PER_MS-1.
- Activity is any of: rise or fall on any channel, or ext_event != ext_event_prev.
- Activity timer:
  - On activity: pcnt <= 0 and to_ms <= 0. Activity has priority over tick in the same cycle.
  - Otherwise, on ms_tick, to_ms increments and saturates at 2^TO_W-1 (no wrap).
- timeout (registered): timeout <= (to_limit_ms != 0) && (to_ms >= to_limit_ms).
  - Deasserts the cycle after activity.
  - A change of to_limit_ms takes effect on the next cycle.
- ext_event_prev <= ext_event every cycle.

Optional Feature:
- Macro: INPUT_COND_LONG_PRESS_EN.
- With the macro defined:
  - Parameter LONG_PRESS_MS (default 1000) and the long_press output are added.
  - Per channel, lcnt counts ms_tick while clean == ~IDLE_LEVEL and clears when clean == IDLE_LEVEL.
  - long_press pulses for 1 cycle when lcnt reaches LONG_PRESS_MS, then lcnt holds. Only one pulse per press.
  - The long_press pulse counts as activity.
  - First pulse occurs between LONG_PRESS_MS-1 and LONG_PRESS_MS ms after the press is debounced.
- Without the macro: the long_press port, its counters and the parameter are absent.

Decomposition:
- Package input_cond_pkg holds:
  - Timeout-select encoding constants (TO_OFF=0, TO_3S=3000, TO_10S=10000, TO_30S=30000), used by software-facing glue to drive to_limit_ms.
  - Default TICKS_PER_MS_27M = 27000.
- Sub-module debounce_ch: one channel's sync chain, dcnt, clean, rise and fall. It is instantiated NUM_CH times via generate.
- Prescaler, activity logic and timeout stay in input_cond.

Test Plan (bench params TICKS_PER_MS=10, DEBOUNCE_MS=2, i.e. 20-cycle debounce, SYNC_STAGES=2, TO_W=8):
- Reset mid-debounce: drive raw_in[0]=0 for 10 cycles, then pulse reset_n low -> clean=2'b11 and all pulses 0 immediately; no fall pulse after release.
- Clean press: raw_in[0] 1->0 and held -> fall[0] high for exactly 1 cycle, 22 cycles after the edge; clean[0]=0; rise stays 0.
- Glitch rejection: raw_in[1] low for 19 cycles then high -> clean[1] stays 1 and no pulses; 20 cycles low -> fall[1].
- Timeout: to_limit_ms=5, no activity -> timeout rises 1 cycle after the 5th ms_tick, which is 50 cycles after reset release. A toggle on ext_event then drops timeout the next cycle, and it reasserts 50 cycles after the toggle.
- Saturation and disable: to_limit_ms=0 for 3000 cycles -> timeout=0 and to_ms holds at 255. Then set to_limit_ms=200 -> timeout=1 the next cycle.
- With INPUT_COND_LONG_PRESS_EN, LONG_PRESS_MS=4: hold raw_in[0]=0 -> exactly one long_press[0] pulse, 30..40 cycles after fall[0]. The pulse also resets timeout.
